// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC sequencing, pipelined SRAM-like word reads, redirect flush.
// Optional FETCH_ADEL_CHECK_EN: misaligned PC emits an address-error marker and halts issue.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'hbfc00000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic [31:0] inst_rdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_adel
);
    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam int          PW     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [31:0] DEPTH_U = 32'(FIFO_DEPTH);
    localparam logic [31:0] MAXO_U  = 32'(MAX_OUTSTANDING);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_entry_t;

    logic          run, hold, hold_stale;
    logic [31:0]   pc, hold_addr, fetch_addr;
    logic [1:0]    outstanding, outstanding_next, discard_cnt;
    logic [PW-1:0] pq_wr, pq_rd;
    logic [31:0]   pend_pc [MAX_OUTSTANDING];
    fetch_entry_t  fifo_mem [FIFO_DEPTH];
    fetch_entry_t  head, push_entry;
    logic [AW-1:0] f_wr, f_rd;
    logic [AW:0]   f_cnt;
    logic          pc_ok, can_issue, accept, stale_acc, dok, drop, push, pop, adel_push;

    function automatic logic [PW-1:0] pq_next(input logic [PW-1:0] p);
        return (32'(p) == MAXO_U - 32'd1) ? '0 : p + 1'b1;
    endfunction

`ifdef FETCH_ADEL_CHECK_EN
    logic halt;
    assign pc_ok      = (pc[1:0] == 2'b00) & ~halt;
    assign fetch_addr = pc;
    // Marker waits for in-flight work to drain so it lands in program order.
    assign adel_push  = run & (pc[1:0] != 2'b00) & ~halt & (outstanding == 2'd0)
                      & (32'(f_cnt) < DEPTH_U) & ~redirect_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)             halt <= 1'b0;
        else if (redirect_valid) halt <= 1'b0;
        else if (adel_push)      halt <= 1'b1;
    end
`else
    assign pc_ok      = 1'b1;
    assign fetch_addr = {pc[31:2], 2'b00};
    assign adel_push  = 1'b0;
`endif

    assign can_issue  = pc_ok & (32'(outstanding) < MAXO_U)
                      & (32'(outstanding) + 32'(f_cnt) < DEPTH_U);
    // A raised request is never withdrawn; after a redirect it finishes on the old address.
    assign inst_req   = run & (hold | can_issue);
    assign inst_addr  = hold ? hold_addr : fetch_addr;
    assign inst_wr    = 1'b0;
    assign inst_size  = 2'b10;
    assign inst_wdata = 32'h0;

    assign accept     = inst_req & inst_addr_ok;
    assign stale_acc  = accept & hold & hold_stale;
    assign dok        = inst_data_ok & (outstanding != 2'd0);
    assign drop       = dok & (discard_cnt != 2'd0);
    assign push       = (dok & ~drop & ~redirect_valid) | adel_push;
    assign pop        = out_valid & out_ready;
    assign outstanding_next = outstanding + {1'b0, accept} - {1'b0, dok};

    assign push_entry = adel_push ? '{pc: pc, inst: 32'h0, adel: 1'b1}
                                  : '{pc: pend_pc[pq_rd], inst: inst_rdata, adel: 1'b0};

    assign head      = fifo_mem[f_rd];
    assign out_valid = (f_cnt != '0);
    assign out_inst  = out_valid ? head.inst : 32'h0;
    assign out_pc    = out_valid ? head.pc   : 32'h0;
    assign out_adel  = out_valid & head.adel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run         <= 1'b0;
            pc          <= RESET_PC;
            hold        <= 1'b0;
            hold_stale  <= 1'b0;
            hold_addr   <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            pq_wr       <= '0;
            pq_rd       <= '0;
            f_wr        <= '0;
            f_rd        <= '0;
            f_cnt       <= '0;
        end else begin
            run         <= 1'b1;
            hold        <= inst_req & ~inst_addr_ok;
            hold_stale  <= inst_req & ~inst_addr_ok & (hold_stale | redirect_valid);
            if (inst_req) hold_addr <= inst_addr;
            outstanding <= outstanding_next;
            if (accept) pq_wr <= pq_next(pq_wr);
            if (dok)    pq_rd <= pq_next(pq_rd);
            if (redirect_valid) begin
                pc          <= redirect_pc;
                discard_cnt <= outstanding_next;
                f_wr        <= '0;
                f_rd        <= '0;
                f_cnt       <= '0;
            end else begin
                if (accept & ~stale_acc) pc <= pc + 32'd4;
                discard_cnt <= discard_cnt + {1'b0, stale_acc} - {1'b0, drop};
                if (push) f_wr <= f_wr + 1'b1;
                if (pop)  f_rd <= f_rd + 1'b1;
                f_cnt <= f_cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) pend_pc[pq_wr] <= pc;
        if (push)   fifo_mem[f_wr] <= push_entry;
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: random in-order memory, random consumer, redirects, resets.
module tb_inst_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'hbfc00000;
    localparam logic [31:0] DMASK    = 32'hdeadbeef;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        redirect_valid, out_valid, out_ready, out_adel;
    logic [31:0] redirect_pc, out_inst, out_pc;

    inst_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .resetn(resetn), .inst_req(inst_req), .inst_wr(inst_wr),
        .inst_size(inst_size), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .out_adel(out_adel)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] inst; logic adel; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    exp_t  exp_q[$];
    mreq_t memq[$];
    int n_checks = 0, n_pass = 0, cyc = 0;
    int ok_pct = 100, ready_pct = 100, lat_lo = 1, lat_hi = 1;
    bit ok_en = 1, seed_on = 0, mark_pc = 0, s_acc, s_dok;
    logic [31:0] seed_pc, s_addr, got_pc, first_acc_addr;
    int dok_total, pop_total, first_acc_cyc, first_vld_cyc, max_out = 0, mis_acc = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Expected output stream: contiguous words from the last redirect/reset target.
    function automatic void reseed(logic [31:0] pc);
        exp_q.delete();
        if (pc[1:0] != 2'b00) begin
            exp_q.push_back('{pc: pc, inst: 32'h0, adel: 1'b1});
            seed_on = 0;
        end else begin
            seed_pc = pc;
            seed_on = 1;
        end
    endfunction

    function automatic void top_up();
        while (seed_on && exp_q.size() < 8) begin
            exp_q.push_back('{pc: seed_pc, inst: seed_pc ^ DMASK, adel: 1'b0});
            seed_pc += 32'd4;
        end
    endfunction

    task automatic step();
        @(negedge clk);
        s_acc  = inst_req & inst_addr_ok;
        s_addr = inst_addr;
        s_dok  = inst_data_ok;
        if (resetn) begin
            if (s_acc && first_acc_cyc < 0) begin first_acc_cyc = cyc; first_acc_addr = inst_addr; end
            if (s_acc && inst_addr[1:0] != 2'b00) mis_acc++;
            if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (s_dok) dok_total++;
            if (out_valid && out_ready) begin
                pop_total++;
                if (mark_pc) begin got_pc = out_pc; mark_pc = 0; end
            end
        end
        @(posedge clk);
        cyc++;
        if (redirect_valid) reseed(redirect_pc);
        assert (!(s_dok && memq.size() == 0));
        if (s_dok && memq.size() > 0) void'(memq.pop_front());
        if (s_acc) memq.push_back('{addr: s_addr, due: cyc + $urandom_range(lat_hi, lat_lo) - 1});
        if (memq.size() > max_out) max_out = memq.size();
        top_up();
        #1;
        inst_data_ok   = (memq.size() > 0) && (memq[0].due <= cyc);
        inst_rdata     = inst_data_ok ? (memq[0].addr ^ DMASK) : 32'h0;
        inst_addr_ok   = ok_en && ($urandom_range(99, 0) < ok_pct);
        out_ready      = ($urandom_range(99, 0) < ready_pct);
        redirect_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_req"},   {31'd0, inst_req},  32'd0);
        chk({tag, "_addr"},  inst_addr,          RESET_PC);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_inst"},  out_inst,           32'd0);
        chk({tag, "_pc"},    out_pc,             32'd0);
        chk({tag, "_adel"},  {31'd0, out_adel},  32'd0);
    endtask

    // Monitor: every consumed head is compared against the scoreboard front.
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL out_unexpected: got pc %h, expected no entry", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc",   out_pc,             e.pc);
                    chk("out_inst", out_inst,           e.inst);
                    chk("out_adel", {31'd0, out_adel},  {31'd0, e.adel});
                end
            end else if (!out_valid) begin
                chk("empty_out", out_pc | out_inst, 32'd0);
            end
        end
    end

    // Request must hold address and stay high until accepted.
    bit prev_wait = 0;
    logic [31:0] prev_addr;
    always @(negedge clk) begin
        if (!resetn) prev_wait = 0;
        else begin
            if (prev_wait) begin
                chk("req_held",  {31'd0, inst_req}, 32'd1);
                chk("addr_held", inst_addr,         prev_addr);
            end
            prev_wait = inst_req & ~inst_addr_ok;
            prev_addr = inst_addr;
        end
    end

    initial begin
        int pb;
        resetn = 0; inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
        redirect_valid = 0; redirect_pc = 0; out_ready = 1;
        dok_total = 0; pop_total = 0; first_acc_cyc = -1; first_vld_cyc = -1; got_pc = 0;
        repeat (3) step();
        chk_reset_vals("rst");
        chk("const_size", {30'd0, inst_size}, 32'd2);
        chk("const_wr", {31'd0, inst_wr} | inst_wdata, 32'd0);

        // Zero-wait memory, always-ready consumer.
        resetn = 1; reseed(RESET_PC);
        repeat (25) step();
        chk("first_latency", 32'(first_vld_cyc - first_acc_cyc), 32'd2);
        chk("first_addr", first_acc_addr, RESET_PC);
        pb = pop_total;
        repeat (10) step();
        chk("throughput", 32'(pop_total - pb), 32'd10);

        // Consumer stall.
        ready_pct = 0;
        repeat (12) step();
        chk("stall_req", {31'd0, inst_req}, 32'd0);
        chk("stall_buffered", 32'(dok_total - pop_total), 32'd4);
        ready_pct = 100;
        repeat (20) step();

        // Long latency, redirect with two in flight.
        lat_lo = 5; lat_hi = 5;
        repeat (20) step();
        for (int i = 0; i < 20 && memq.size() != 2; i++) step();
        chk("two_in_flight", 32'(memq.size()), 32'd2);
        redirect_valid = 1; redirect_pc = 32'h80001000;
        step();
        mark_pc = 1; got_pc = 0;
        repeat (40) step();
        chk("redir1_first_pc", got_pc, 32'h80001000);

        // Redirect colliding with data_ok and an unaccepted request.
        lat_lo = 1; lat_hi = 1;
        repeat (10) step();
        for (int i = 0; i < 20; i++) begin step(); if (s_acc) break; end
        ok_en = 0; inst_addr_ok = 0;
        redirect_valid = 1; redirect_pc = 32'h80002000;
        step(); step(); step();
        ok_en = 1; mark_pc = 1; got_pc = 0;
        repeat (30) step();
        chk("redir2_first_pc", got_pc, 32'h80002000);

        // Random traffic.
        lat_lo = 1; lat_hi = 4; ok_pct = 70; ready_pct = 75;
        for (int i = 0; i < 1500; i++) begin
            step();
            if ($urandom_range(39, 0) == 0) begin
                redirect_valid = 1;
                redirect_pc = $urandom() & 32'hfffffffc;
            end
        end
        lat_lo = 1; lat_hi = 1; ok_pct = 100; ready_pct = 100;
        repeat (30) step();
        chk("max_outstanding", {31'd0, max_out <= 2}, 32'd1);

        // Asynchronous reset mid-stream.
        lat_lo = 5; lat_hi = 5;
        for (int i = 0; i < 20 && memq.size() != 2; i++) step();
        resetn = 0; memq.delete(); exp_q.delete(); seed_on = 0; inst_data_ok = 0;
        #1;
        chk_reset_vals("mid_rst");
        step(); step();
        lat_lo = 1; lat_hi = 1;
        resetn = 1; reseed(RESET_PC); first_acc_cyc = -1; mark_pc = 1; got_pc = 0;
        repeat (20) step();
        chk("restart_addr", first_acc_addr, RESET_PC);
        chk("restart_first_pc", got_pc, RESET_PC);

`ifdef FETCH_ADEL_CHECK_EN
        redirect_valid = 1; redirect_pc = 32'h80000002; mis_acc = 0;
        step();
        repeat (15) step();
        chk("adel_no_req", 32'(mis_acc), 32'd0);
        chk("adel_idle_req", {31'd0, inst_req}, 32'd0);
        chk("adel_entry_seen", 32'(exp_q.size()), 32'd0);
        redirect_valid = 1; redirect_pc = 32'h80000000;
        step();
        mark_pc = 1; got_pc = 0;
        repeat (20) step();
        chk("adel_resume_pc", got_pc, 32'h80000000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch front end sitting directly upstream of the SRAM-like instruction port (`inst_req`/`inst_addr_ok`/`inst_data_ok`) that feeds the CPU-to-AXI bridge or the direct SRAM glue. Maintains the fetch PC, issues pipelined word reads with up to `MAX_OUTSTANDING` requests in flight, and pairs each returned word with its PC. Results are buffered in a small FIFO toward decode. Branch/exception redirects flush the buffer and discard stale in-flight responses.

## Interface
Parameters:
- `RESET_PC`, 32'hbfc00000, first fetch address after reset
- `FIFO_DEPTH`, 4, instruction buffer entries (power of two, ≥2)
- `MAX_OUTSTANDING`, 2, accepted-but-unanswered requests allowed (1..3)

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  asynchronous active-low reset
- `inst_req`  out  1  request valid
- `inst_wr`  out  1  constant 0
- `inst_size`  out  2  constant 2'b10 (word)
- `inst_addr`  out  32  fetch address
- `inst_wdata`  out  32  constant 0
- `inst_rdata`  in  32  returned word, valid with `inst_data_ok`
- `inst_addr_ok`  in  1  request accepted this cycle
- `inst_data_ok`  in  1  response returned this cycle, in request order
- `redirect_valid`  in  1  flush and refetch from `redirect_pc`
- `redirect_pc`  in  32  new fetch PC
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  decode accepts head
- `out_inst`  out  32  head instruction word
- `out_pc`  out  32  head PC
- `out_adel`  out  1  head is an address-error (misaligned PC) marker

## Operation
- State: `pc`, pending-PC queue (depth `MAX_OUTSTANDING`), `discard_cnt`, instruction FIFO of {pc, inst, adel}.
- Issue: `inst_req`=1 when `outstanding < MAX_OUTSTANDING` and `outstanding + fifo_count < FIFO_DEPTH` and not halted. `inst_addr`=`pc`.
- Request, once raised, holds `inst_addr` stable and stays high until `inst_addr_ok`; never withdrawn, even on redirect.
- On accept (`inst_req & inst_addr_ok`): push `pc` to pending queue, `pc <= pc+4` (wraps modulo 2^32).
- On `inst_data_ok`: pop pending queue. If `discard_cnt>0`, decrement and drop; else push {pc, `inst_rdata`, 0} to FIFO.
- Out handshake: pop when `out_valid & out_ready`. `out_inst`/`out_pc`/`out_adel` are 0 when FIFO empty.
- Redirect (has priority over all same-cycle events): FIFO cleared, `pc <= redirect_pc`, halt cleared, `discard_cnt <= outstanding_next`. `outstanding_next` counts every accepted-not-returned request after this cycle, including one accepted this cycle. A response returning this cycle is dropped. A head popped this cycle is the consumer's to discard.
- Unaccepted pending request at redirect: completes its handshake on old address; counted into discard at acceptance.
- `data_ok` without outstanding request: protocol error, ignored (assertion in bench).

## Timing
- Reset values: `inst_req` 0, `inst_addr` `RESET_PC`, `out_valid` 0, `out_inst`/`out_pc` 0, `out_adel` 0, all counters 0.
- First `inst_req` in the first `clk` edge after `resetn` deasserts.
- Accept at cycle T, `data_ok` at T+1 (SRAM glue) → `out_valid` at T+2 (registered FIFO, no bypass).
- Back-to-back: with zero-wait memory and `out_ready`=1, sustains one instruction per cycle.
- Simultaneous FIFO push and pop on full FIFO allowed; credit check guarantees no overflow.
- Full FIFO with `out_ready`=0: `inst_req` drops once credits exhausted; in-flight responses always have a slot.

## Configuration
- `FETCH_ADEL_CHECK_EN` defined: when `pc[1:0]!=0` no request issued; once outstanding drains to 0, push {pc, 0, 1} and halt issuing until redirect.
- Undefined: `out_adel` tied 0, `inst_addr` = {pc[31:2],2'b00}, fetch proceeds normally.

## Test plan
- Reset release, zero-wait memory returning addr as data, `out_ready`=1 → out_pc 0xbfc00000, 0xbfc00004, … one per cycle, first `out_valid` 2 cycles after first accept.
- `out_ready`=0 for 10 cycles → exactly 4 entries buffered, `inst_req` low, no entry lost or duplicated after release.
- AXI-like latency 5 cycles, `addr_ok` immediate → at most 2 outstanding; redirect to 0x80001000 with 2 in flight → both responses dropped, next out_pc 0x80001000.
- Redirect on same cycle as `inst_data_ok` and an unaccepted request (`addr_ok` held 0 for 3 cycles) → old response dropped, old request accepted later and dropped, no stale PC on output.
- With `FETCH_ADEL_CHECK_EN`: redirect to 0x80000002 → no request issued, single entry out_pc 0x80000002, `out_adel`=1, then idle until redirect to 0x80000000 resumes fetch.
- `resetn` asserted mid-stream with 2 outstanding → all outputs at reset values immediately; fetch restarts at 0xbfc00000.
